// File: rtl/mem_port_responder_if.sv
// CPU memory-port bundle between an initiator (master) and a responder (slave).
// Command fields are driven by the master; o_* completion fields by the slave.
interface mem_port_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   i_MAddr;
  logic                    i_MCmd;
  logic                    i_MRnW;
  logic [DATA_WIDTH/8-1:0] i_MBen;
  logic [DATA_WIDTH-1:0]   i_MData;
  logic [DATA_WIDTH-1:0]   o_MData;
  logic                    o_MRdy;
  logic                    o_MErr;

  modport master (
    output i_MAddr, i_MCmd, i_MRnW, i_MBen, i_MData,
    input  o_MData, o_MRdy, o_MErr
  );

  modport slave (
    input  i_MAddr, i_MCmd, i_MRnW, i_MBen, i_MData,
    output o_MData, o_MRdy, o_MErr
  );
endinterface

// File: rtl/mem_port_responder.sv
// Single-ported memory acting as memory-port responder with WAIT_STATES wait cycles.
// Optional MEM_PORT_RESP_ERR_CHECK_EN flags misaligned / out-of-range accesses.
//
// state   | meaning
// IDLE    | no access outstanding, ready for a command
// WAIT    | access accepted, counting down wait states, ready low
// RESP    | completion cycle, read data / error valid, ready high
module mem_port_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  mem_port_responder_if.slave   mp
);

  localparam int BEN_W = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rdy;
  logic                  accept;
  logic                  access;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rnw_q;
  logic [BEN_W-1:0]      ben_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  from_wait;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_rnw;
  logic [BEN_W-1:0]      acc_ben;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [IDX_W-1:0]      acc_idx;
  logic                  acc_err;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  assign rdy    = (state_q != ST_WAIT);
  assign accept = mp.i_MCmd && rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = ST_RESP;
            access  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= mp.i_MAddr;
      rnw_q   <= mp.i_MRnW;
      ben_q   <= mp.i_MBen;
      wdata_q <= mp.i_MData;
    end
  end

  // With zero wait states the access happens on the accept edge, so use the live command.
  assign from_wait = (state_q == ST_WAIT);
  assign acc_addr  = from_wait ? addr_q  : mp.i_MAddr;
  assign acc_rnw   = from_wait ? rnw_q   : mp.i_MRnW;
  assign acc_ben   = from_wait ? ben_q   : mp.i_MBen;
  assign acc_wdata = from_wait ? wdata_q : mp.i_MData;
  assign acc_idx   = acc_addr[IDX_W+1:2];

`ifdef MEM_PORT_RESP_ERR_CHECK_EN
  logic err_q;

  assign acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (IDX_W + 2)) != '0);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= access && acc_err;
    end
  end

  assign mp.o_MErr = err_q;
`else
  logic unused_addr_bits;

  assign acc_err          = 1'b0;
  assign unused_addr_bits = ^{acc_addr[1:0], acc_addr[ADDR_WIDTH-1:IDX_W+2]};
  assign mp.o_MErr        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (nrst && access && !acc_rnw && !acc_err) begin
      for (int b = 0; b < BEN_W; b++) begin
        if (acc_ben[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read data lives only for the RESP cycle; every other cycle it returns to zero.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rdata_q <= '0;
    end else if (access && acc_rnw && !acc_err) begin
      rdata_q <= mem[acc_idx];
    end else begin
      rdata_q <= '0;
    end
  end

  assign mp.o_MData = rdata_q;
  assign mp.o_MRdy  = rdy;

endmodule

// File: tb/tb_mem_port_responder.sv
// Bench for mem_port_responder: three instances (WAIT_STATES 2, 0, 3) against a
// cycle-timeline model, plus directed accesses with literal expected results.
module tb_mem_port_responder;

  localparam int MW = 64;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic        cmd    [3];
  logic        rnw_i  [3];
  logic [31:0] addr_i [3];
  logic [3:0]  ben_i  [3];
  logic [31:0] wd_i   [3];
  logic        rdy_o  [3];
  logic        err_o  [3];
  logic [31:0] rdata_o[3];

  mem_port_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mp0 ();
  mem_port_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mp1 ();
  mem_port_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mp2 ();

  assign mp0.i_MCmd = cmd[0];  assign mp0.i_MRnW = rnw_i[0]; assign mp0.i_MAddr = addr_i[0];
  assign mp0.i_MBen = ben_i[0]; assign mp0.i_MData = wd_i[0];
  assign rdy_o[0] = mp0.o_MRdy; assign err_o[0] = mp0.o_MErr; assign rdata_o[0] = mp0.o_MData;
  assign mp1.i_MCmd = cmd[1];  assign mp1.i_MRnW = rnw_i[1]; assign mp1.i_MAddr = addr_i[1];
  assign mp1.i_MBen = ben_i[1]; assign mp1.i_MData = wd_i[1];
  assign rdy_o[1] = mp1.o_MRdy; assign err_o[1] = mp1.o_MErr; assign rdata_o[1] = mp1.o_MData;
  assign mp2.i_MCmd = cmd[2];  assign mp2.i_MRnW = rnw_i[2]; assign mp2.i_MAddr = addr_i[2];
  assign mp2.i_MBen = ben_i[2]; assign mp2.i_MData = wd_i[2];
  assign rdy_o[2] = mp2.o_MRdy; assign err_o[2] = mp2.o_MErr; assign rdata_o[2] = mp2.o_MData;

  mem_port_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(MW), .WAIT_STATES(2))
    u_ws2 (.clk(clk), .nrst(nrst), .mp(mp0));
  mem_port_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(MW), .WAIT_STATES(0))
    u_ws0 (.clk(clk), .nrst(nrst), .mp(mp1));
  mem_port_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(MW), .WAIT_STATES(3))
    u_ws3 (.clk(clk), .nrst(nrst), .mp(mp2));

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: an access accepted in cycle N holds ready low for cycles N+1..N+WS and
  // completes in cycle N+WS+1; the array effect is applied on entry to that cycle.
  int          ws_tab [3] = '{2, 0, 3};
  int          cyc = 0;
  int          acc_c [3] = '{-1, -1, -1};
  int          rsp_c [3] = '{-1, -1, -1};
  logic        pend  [3] = '{1'b0, 1'b0, 1'b0};
  logic        p_rnw [3];
  logic [31:0] p_addr[3];
  logic [3:0]  p_ben [3];
  logic [31:0] p_data[3];
  logic [31:0] res_data[3];
  logic        res_err [3];
  logic [31:0] mmem [3][MW];

  function automatic logic exp_rdy(input int d, input int c);
    return !(c > acc_c[d] && c < rsp_c[d]);
  endfunction

  task automatic model_access(input int d);
    int   idx;
    logic bad;
`ifdef MEM_PORT_RESP_ERR_CHECK_EN
    bad = (p_addr[d][1:0] != 2'b00) || (p_addr[d] >= 32'(MW * 4));
`else
    bad = 1'b0;
`endif
    idx = int'((p_addr[d] >> 2) % MW);
    res_err[d]  = bad;
    res_data[d] = 32'h0;
    if (!bad) begin
      if (p_rnw[d]) begin
        res_data[d] = mmem[d][idx];
      end else begin
        for (int b = 0; b < 4; b++)
          if (p_ben[d][b]) mmem[d][idx][8*b +: 8] = p_data[d][8*b +: 8];
      end
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      if (!nrst) begin
        acc_c[d] = -1;
        rsp_c[d] = -1;
        pend[d]  = 1'b0;
      end else begin
        if (cmd[d] && exp_rdy(d, cyc)) begin
          acc_c[d]  = cyc;
          rsp_c[d]  = cyc + ws_tab[d] + 1;
          pend[d]   = 1'b1;
          p_rnw[d]  = rnw_i[d];
          p_addr[d] = addr_i[d];
          p_ben[d]  = ben_i[d];
          p_data[d] = wd_i[d];
        end
        if (pend[d] && rsp_c[d] == cyc + 1) begin
          model_access(d);
          pend[d] = 1'b0;
        end
      end
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("rdy_dut%0d", d), 32'(rdy_o[d]), 32'(exp_rdy(d, cyc)));
        chk($sformatf("err_dut%0d", d), 32'(err_o[d]), 32'((cyc == rsp_c[d]) && res_err[d]));
        chk($sformatf("data_dut%0d", d), rdata_o[d], (cyc == rsp_c[d]) ? res_data[d] : 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input int d, input logic rnw, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lowc);
    int n;
    n = 0;
    while (!rdy_o[d] && n < 50) begin tick(); n++; end
    cmd[d] = 1'b1; rnw_i[d] = rnw; addr_i[d] = a; ben_i[d] = be; wd_i[d] = wd;
    tick();
    cmd[d] = 1'b0;
    lowc = 0;
    while (!rdy_o[d] && lowc < 50) begin lowc++; tick(); end
    chk("resp_seen", 32'(rdy_o[d]), 32'd1);
    rd = rdata_o[d];
    er = err_o[d];
    tick();
  endtask

  logic [31:0] rd;
  logic        er;
  int          lowc;
  int          n;

  initial begin
    for (int d = 0; d < 3; d++) begin
      cmd[d] = 1'b0; rnw_i[d] = 1'b0; addr_i[d] = 32'h0; ben_i[d] = 4'h0; wd_i[d] = 32'h0;
    end
    nrst = 1'b0;
    repeat (3) tick();
    chk_en = 1'b1;
    nrst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_rdy", 32'(rdy_o[0]), 32'd1);
      chk("idle_err", 32'(err_o[0]), 32'd0);
      chk("idle_data", rdata_o[0], 32'h0);
    end

    access(0, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lowc);
    chk("wr10_lowc", 32'(lowc), 32'd2);
    access(0, 1'b1, 32'h10, 4'h0, 32'h0, rd, er, lowc);
    chk("rd10_lowc", 32'(lowc), 32'd2);
    chk("rd10_data", rd, 32'hDEADBEEF);
    chk("rd10_after", rdata_o[0], 32'h0);

    access(0, 1'b0, 32'h20, 4'hF, 32'h11223344, rd, er, lowc);
    access(0, 1'b0, 32'h20, 4'b0101, 32'hAABBCCDD, rd, er, lowc);
    access(0, 1'b1, 32'h20, 4'h0, 32'h0, rd, er, lowc);
    chk("lanes_data", rd, 32'h11BB33DD);

    cmd[1] = 1'b1; rnw_i[1] = 1'b0; addr_i[1] = 32'h0; ben_i[1] = 4'hF; wd_i[1] = 32'h5;
    tick();
    chk("b2b_wr_resp_rdy", 32'(rdy_o[1]), 32'd1);
    rnw_i[1] = 1'b1; wd_i[1] = 32'h0;
    tick();
    cmd[1] = 1'b0;
    chk("b2b_rd_data", rdata_o[1], 32'h5);
    tick();

    access(2, 1'b0, 32'h34, 4'hF, 32'h1234, rd, er, lowc);
    chk("ws3_lowc", 32'(lowc), 32'd3);
    cmd[2] = 1'b1; rnw_i[2] = 1'b0; addr_i[2] = 32'h38; ben_i[2] = 4'hF; wd_i[2] = 32'hCAFE;
    tick();
    chk("ws3_busy", 32'(rdy_o[2]), 32'd0);
    addr_i[2] = 32'h34; wd_i[2] = 32'h9999;
    tick();
    cmd[2] = 1'b0;
    n = 0;
    while (!rdy_o[2] && n < 50) begin tick(); n++; end
    tick();
    access(2, 1'b1, 32'h34, 4'h0, 32'h0, rd, er, lowc);
    chk("ignored_cmd_data", rd, 32'h1234);
    access(2, 1'b1, 32'h38, 4'h0, 32'h0, rd, er, lowc);
    chk("ws3_wr38_data", rd, 32'hCAFE);

    access(0, 1'b0, 32'h0, 4'hF, 32'h600D, rd, er, lowc);
    access(0, 1'b1, 32'h2, 4'h0, 32'h0, rd, er, lowc);
`ifdef MEM_PORT_RESP_ERR_CHECK_EN
    chk("misalign_err", 32'(er), 32'd1);
    chk("misalign_data", rd, 32'h0);
`else
    chk("misalign_err", 32'(er), 32'd0);
    chk("misalign_data", rd, 32'h600D);
`endif
    access(0, 1'b0, 32'(MW * 4), 4'hF, 32'hBAD0, rd, er, lowc);
`ifdef MEM_PORT_RESP_ERR_CHECK_EN
    chk("range_err", 32'(er), 32'd1);
`else
    chk("range_err", 32'(er), 32'd0);
`endif
    access(0, 1'b1, 32'h0, 4'h0, 32'h0, rd, er, lowc);
`ifdef MEM_PORT_RESP_ERR_CHECK_EN
    chk("word0_after_err", rd, 32'h600D);
`else
    chk("word0_after_wrap", rd, 32'hBAD0);
`endif

    access(2, 1'b0, 32'h8, 4'hF, 32'h1111, rd, er, lowc);
    cmd[2] = 1'b1; rnw_i[2] = 1'b0; addr_i[2] = 32'h8; ben_i[2] = 4'hF; wd_i[2] = 32'h77;
    tick();
    cmd[2] = 1'b0;
    nrst = 1'b0;
    tick();
    chk("rst_rdy", 32'(rdy_o[2]), 32'd1);
    chk("rst_err", 32'(err_o[2]), 32'd0);
    chk("rst_data", rdata_o[2], 32'h0);
    nrst = 1'b1;
    tick();
    access(2, 1'b1, 32'h8, 4'h0, 32'h0, rd, er, lowc);
    chk("rst_dropped_write", rd, 32'h1111);

    repeat (3) tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_responder.md
# mem_port_responder

Single-ported on-chip memory that acts as the responder (slave) end of the CPU memory-port protocol. It accepts a command from an initiator such as a core D-Port or I-Port and performs a word/byte-lane write or a word read against an internal array. It returns completion through a ready/error handshake after a configurable number of wait states. It sits between the CPU top and the rest of the system as boot ROM/RAM and as a protocol reference responder for benches.

## Interface
Parameters:
- ADDR_WIDTH, default 32: byte address width.
- DATA_WIDTH, default 32: data width; byte-enable width is DATA_WIDTH/8.
- MEM_WORDS, default 1024: array depth in words; must be a power of two.
- WAIT_STATES, default 2: cycles with ready low per access; legal range 0..15.

Ports:
- clk, input, 1: the single clock; all logic on rising edge.
- nrst, input, 1: reset, synchronous, active-low.
- i_MAddr, input, ADDR_WIDTH: byte address of the command.
- i_MCmd, input, 1: command strobe; one cycle per command.
- i_MRnW, input, 1: 1 = read, 0 = write.
- i_MBen, input, DATA_WIDTH/8: byte-lane enables for writes; bit k covers data bits [8k+7:8k].
- i_MData, input, DATA_WIDTH: write data.
- o_MData, output, DATA_WIDTH: read data.
- o_MRdy, output, 1: responder idle or completing; commands are accepted only while high.
- o_MErr, output, 1: error flag for the completing access.

## Operation
- States: IDLE, WAIT, RESP.
- Accept rule: a command is accepted when i_MCmd=1 and o_MRdy=1, in IDLE or RESP. When o_MRdy=0, i_MCmd is ignored and the command is not queued.
- On accept, the block captures addr, rnw, ben and data.
  - WAIT_STATES>0: go to WAIT and load the 4-bit counter with WAIT_STATES-1.
  - WAIT_STATES=0: go straight to RESP.
- WAIT: counter decrements each cycle. At 0 the next state is RESP.
- RESP lasts one cycle.
  - With a new accept in this cycle, the block restarts as above (back-to-back).
  - Otherwise it goes to IDLE.
- Array access happens on the edge that enters RESP, on word index addr[log2(MEM_WORDS)+1:2].
  - Write: only lanes with i_MBen=1 are updated. Ben=0 is a legal no-op.
  - Read: the word is registered into o_MData.
- Outputs by state:
  - o_MData equals the read word only in RESP of a successful read; it is 0 in every other cycle.
  - o_MErr is 1 only in RESP of a failed access.
  - o_MRdy = 0 in WAIT, 1 in IDLE and RESP.
- Read-after-write: a read accepted in the write's RESP cycle returns the new data.
- Array contents are not initialised by reset.

## Timing
- Reset values: o_MRdy=1, o_MErr=0, o_MData=0, state IDLE, counter 0.
- Command accepted in cycle N:
  - o_MRdy=0 in cycles N+1 .. N+WAIT_STATES.
  - Response cycle is N+WAIT_STATES+1, with o_MRdy=1 and o_MData/o_MErr valid.
- The response cycle is defined as the first o_MRdy=1 cycle after an accept.
- Throughput: one access per WAIT_STATES+1 cycles with back-to-back commands.
- Reset asserted mid-access:
  - The next cycle shows the reset values.
  - A pending write is dropped, and an access not yet in RESP never reaches the array.

## Configuration
- MEM_PORT_RESP_ERR_CHECK_EN defined: an access is an error if addr[1:0]≠0 or addr ≥ MEM_WORDS*4.
  - An erroring access does not touch the array.
  - Its RESP cycle drives o_MErr=1 and o_MData=0.
- MEM_PORT_RESP_ERR_CHECK_EN undefined: no checking is done.
  - addr[1:0] and the upper address bits are ignored, so addresses wrap modulo MEM_WORDS*4.
  - o_MErr is constant 0.

## Test plan
- Reset then idle: o_MRdy=1, o_MErr=0, o_MData=0 for 10 cycles with i_MCmd=0.
- Read latency, WAIT_STATES=2:
  - Stimulus: write 0xDEADBEEF to 0x10 with ben=4'hF, then read 0x10.
  - Required: o_MRdy low for exactly 2 cycles, o_MData=0xDEADBEEF in the third cycle, 0 the cycle after.
- Byte lanes:
  - Stimulus: write 0x11223344 to 0x20 with ben=4'hF, then write 0xAABBCCDD with ben=4'b0101, then read 0x20.
  - Required: read returns 0x11BB33DD.
- Back-to-back and ignored command, WAIT_STATES=0:
  - Stimulus: write 0x5 to 0x0, then read 0x0 in the write's RESP cycle.
  - Required: read returns 0x5.
  - Repeat with WAIT_STATES=3 and pulse i_MCmd while o_MRdy=0. Required: that command is ignored and the array is unchanged.
- Errors, macro defined:
  - Stimulus: read 0x2, then write to MEM_WORDS*4.
  - Required: each RESP has o_MErr=1 and o_MData=0, and a subsequent read of 0x0 is unchanged.
  - Same stimulus with the macro undefined. Required: o_MErr=0, and the write lands at word 0.
- Reset mid-access, WAIT_STATES=3:
  - Stimulus: write 0x77 to 0x8, then drop nrst one cycle after accept.
  - Required: the next cycle shows reset values, and a later read of 0x8 returns the prior contents, not 0x77.
